fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] are zero.
REQ-002 Single clock; reset is asynchronous and active-low. Ports: clk, rst_n.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  instruction memory accepts the request.
REQ-007 imem_addr  out  32  fetch address, equal to pc.
REQ-008 imem_rsp_valid  in  1  instruction word present.
REQ-009 imem_rsp_data  in  32  instruction word.
REQ-010 redirect_valid  in  1  branch taken or flush request.
REQ-011 redirect_pc  in  32  new fetch target.
REQ-012 id_ready  in  1  decode/control stage accepts the instruction.
REQ-013 id_valid  out  1  registered instruction valid to decode.
REQ-014 id_pc  out  32  address of the held instruction.
REQ-015 id_instr  out  32  held instruction word.
REQ-016 opcode/funct3/funct7/rd/rs1/rs2  out  7/3/7/5/5/5  fields taken from id_instr bits [6:0], [14:12], [31:25], [11:7], [19:15], [24:20].

Function
REQ-017 The block SHALL use the states IDLE, FETCH, WAIT and HOLD, plus a 1-bit kill flag.
REQ-018 IDLE SHALL move to FETCH on the next clock with no other condition.
REQ-019 imem_req_valid SHALL equal (state==FETCH), and imem_addr SHALL equal pc at all times.
REQ-020 In FETCH, when imem_req_ready=1, the state SHALL become WAIT; only one request is outstanding at a time.
REQ-021 In WAIT, a response with imem_rsp_valid=1 and kill=0 SHALL have the following effects on the next clock:
- id_instr <= imem_rsp_data and all field outputs are registered;
- id_pc <= pc, pc <= pc+4 and id_valid <= 1;
- the state becomes HOLD.
REQ-022 In WAIT, a response with kill=1 SHALL be discarded: id_valid stays 0, kill is cleared, pc is unchanged and the state becomes FETCH.
REQ-023 In HOLD, id_valid=1 and all id_* outputs SHALL stay stable until id_ready=1. On id_ready=1 the next clock SHALL set id_valid=0 and the state to FETCH.
REQ-024 Minimum throughput SHALL be one instruction per 3 cycles: FETCH, WAIT and HOLD, each lasting one cycle.
REQ-025 redirect_valid SHALL set pc <= {redirect_pc[31:2],2'b00} on the next clock in every state except IDLE, and redirect has priority over the pc+4 update.
REQ-026 Redirect in FETCH without imem_req_ready SHALL stay in FETCH, and the new pc is presented on the next cycle.
REQ-027 Redirect in FETCH with imem_req_ready=1 SHALL go to WAIT with kill=1.
REQ-028 Redirect in WAIT without a response SHALL set kill=1.
REQ-029 Redirect in WAIT in the same cycle as a response SHALL discard the response, go to FETCH and leave kill=0.
REQ-030 Redirect in HOLD SHALL clear id_valid and go to FETCH, whether or not id_ready is high; a simultaneous id_ready counts as a completed handshake.
REQ-031 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-032 pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-033 While rst_n=0, asynchronously:
- state=IDLE, pc=RESET_PC, kill=0;
- id_valid=0, id_pc=0, id_instr=0 and all field outputs 0;
- imem_req_valid=0.
REQ-034 Reset asserted mid-transaction SHALL abandon the outstanding request. The first response after rst_n rises SHALL be accepted only in WAIT, under REQ-031.

Verification
REQ-035 Reset release, memory always ready, responding one cycle after acceptance, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; id_valid pulses every 3rd cycle. For instruction 0x00A28293: opcode=0x13, funct3=0, rd=5, rs1=5.
REQ-036 id_ready=0 for 5 cycles in HOLD -> id_valid, id_pc and id_instr stay constant and no new imem_req_valid is issued; after id_ready=1, the next fetch is at id_pc+4.
REQ-037 Redirect to 0x103 in WAIT, response two cycles later -> response dropped, id_valid stays 0, next imem_addr=0x100.
REQ-038 Redirect to 0x200 in HOLD in the same cycle as id_ready=1 -> id_valid falls and the next request address is 0x200, not id_pc+4.
REQ-039 Fetch at pc=0xFFFF_FFFC -> id_pc=0xFFFF_FFFC and the next imem_addr=0x0000_0000.
REQ-040 rst_n pulsed low during WAIT -> all outputs go to 0 immediately; after release, the fetch restarts at RESET_PC and a stale imem_rsp_valid arriving in FETCH is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Single-outstanding instruction fetch stage. It sends one request to
// instruction memory, waits for the word, and holds it registered toward
// decode until decode takes it. Redirects (taken branch or flush) replace the
// pc. Any response already in flight for the old pc is dropped.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   imem_req_valid      request valid (high exactly while in FETCH)
//   imem_req_ready      memory accepts the request this cycle
//   imem_addr           request address, always equal to pc
//   imem_rsp_valid      instruction word present (only sampled in WAIT)
//   imem_rsp_data       instruction word
//   redirect_valid      replace pc with redirect_pc (word aligned)
//   redirect_pc         new fetch target
//   id_ready            decode accepts the held instruction
//   id_valid            held instruction valid
//   id_pc, id_instr     address and word of the held instruction
//   opcode .. rs2       registered decode fields of id_instr
//   dbg_state           current FSM state (IDLE=0, FETCH=1, WAIT=2, HOLD=3)
//
// Handshake semantics (both the imem request and the decode output):
//   a transfer happens on a rising edge where valid && ready are both high.
//   valid never depends combinationally on ready. While valid is high and
//   ready is low, the payload (address / id_* outputs) stays stable. A
//   redirect is the only event allowed to withdraw a pending id_valid.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,

    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    // Set when the response now in flight belongs to a pc that has since
    // been redirected away. That response must be dropped on arrival.
    logic        kill;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        unused_redirect_low;

    // Redirect targets are forced to word alignment. The low bits are
    // deliberately discarded.
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];

    // Wraps modulo 2^32 by construction (32-bit result).
    assign pc_plus4 = pc + 32'd4;

    assign imem_req_valid = (state == FETCH);
    assign imem_addr      = pc;
    assign dbg_state      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            id_valid <= 1'b0;
            id_pc    <= 32'h0;
            id_instr <= 32'h0;
            opcode   <= 7'h0;
            funct3   <= 3'h0;
            funct7   <= 7'h0;
            rd       <= 5'h0;
            rs1      <= 5'h0;
            rs2      <= 5'h0;
        end else begin
            case (state)
                // One idle cycle after reset, then start fetching. Redirects
                // are not honoured here.
                IDLE: begin
                    state <= FETCH;
                end

                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    if (imem_req_ready) begin
                        state <= WAIT;
                        // The accepted request carried the old pc. If a
                        // redirect arrived in the same cycle, its response is
                        // stale.
                        kill  <= redirect_valid;
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        if (imem_rsp_valid) begin
                            // The response arrives with the redirect. Drop it
                            // and refetch right away. Nothing is left in
                            // flight, so kill is clear.
                            state <= FETCH;
                            kill  <= 1'b0;
                        end else begin
                            kill  <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            id_valid <= 1'b1;
                            id_pc    <= pc;
                            id_instr <= imem_rsp_data;
                            opcode   <= imem_rsp_data[6:0];
                            funct3   <= imem_rsp_data[14:12];
                            funct7   <= imem_rsp_data[31:25];
                            rd       <= imem_rsp_data[11:7];
                            rs1      <= imem_rsp_data[19:15];
                            rs2      <= imem_rsp_data[24:20];
                            pc       <= pc_plus4;
                            state    <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    // A redirect withdraws the held instruction whether or not
                    // decode takes it in the same cycle. Either way the next
                    // fetch is at the redirect target.
                    if (redirect_valid) begin
                        pc       <= redirect_target;
                        id_valid <= 1'b0;
                        state    <= FETCH;
                    end else if (id_ready) begin
                        id_valid <= 1'b0;
                        state    <= FETCH;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
